round_key_store: RTL and testbench

- Reader/consumer at the far end of the key-expansion queue. Captures the 11 AES-128 round keys that the queue emits (16 byte lanes K0..KF plus Rcon_out, gated by empty) into an 11-entry register file.
- Serves registered random reads to the cipher datapath, in forward order for encryption or reversed order for decryption.
- Checks the Rcon sequence on the fly and flags a corrupted expansion stream.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/rcon_checker.sv | 18 +
 rtl/round_key_store.sv | 95 +++++++++
 tb/tb_round_key_store.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: Rcon table, round-key count, store states
// and a byte-lane helper (lane 0 is the most significant byte).
package aes_pkg;

  localparam int unsigned NUM_ROUND_KEYS = 11;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {StIdle, StFill, StReady} store_state_e;

  // Expected Rcon for round-key slot idx (1..10); 0 outside that range.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [3:0] pos;
    logic [7:0] r;
    r   = 8'h00;
    pos = idx - 4'd1;
    if (idx >= 4'd1 && idx <= 4'd10) r = RCON[pos];
    return r;
  endfunction

  function automatic logic [7:0] key_byte(input logic [127:0] k, input logic [3:0] lane);
    logic [127:0] s;
    s = k << {lane, 3'b000};
    return s[127:120];
  endfunction

endpackage

// File: rtl/rcon_checker.sv
// Combinational Rcon check: looks up the expected Rcon for a slot index and flags
// a mismatch. Slot 0 carries the cipher key and is never flagged.
module rcon_checker
  import aes_pkg::*;
(
  input  logic [3:0] slot,
  input  logic [7:0] rcon,
  output logic       mismatch
);

  logic [7:0] expected;

  always_comb begin
    expected = rcon_lookup(slot);
    mismatch = (slot != 4'd0) && (rcon != expected);
  end

endmodule

// File: rtl/round_key_store.sv
// Captures the 11 AES-128 round keys from the expansion queue into a register file
// and serves registered forward/inverse reads once the full set is present.
module round_key_store
  import aes_pkg::*;
#(
  parameter int unsigned KEY_W      = 128,
  parameter int unsigned ROUNDS     = 10,
  parameter bit          CHECK_RCON = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [KEY_W-1:0] k_in,
  input  logic [7:0]       rcon_in,
  input  logic             empty_in,
  input  logic             rd_req,
  input  logic             rd_dir,
  input  logic [3:0]       rd_round,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid,
  output logic             full,
  output logic             busy,
  output logic [3:0]       count,
  output logic             rcon_err
);

  localparam logic [3:0] LAST = 4'(ROUNDS);

  store_state_e     state;
  logic [KEY_W-1:0] slots [NUM_ROUND_KEYS];
  logic             rcon_bad;
  logic             rcon_fail;
  logic             word_in;
  logic             slot_we;
  logic [3:0]       rd_idx;

  rcon_checker u_rcon_checker (
    .slot     (count),
    .rcon     (rcon_in),
    .mismatch (rcon_bad)
  );

  assign rcon_fail = CHECK_RCON && rcon_bad;
  // load wins over a same-cycle word, so the word is never captured
  assign word_in   = (state == StFill) && !empty_in && !load;
  assign slot_we   = !reset && word_in && !rcon_fail;
  assign rd_idx    = rd_dir ? (LAST - rd_round) : rd_round;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= StIdle;
      full     <= 1'b0;
      busy     <= 1'b0;
      count    <= 4'd0;
      rcon_err <= 1'b0;
      rd_valid <= 1'b0;
      rd_key   <= '0;
    end else begin
      if (rd_req && full && !load) begin
        rd_valid <= 1'b1;
        rd_key   <= (rd_round > LAST) ? '0 : slots[rd_idx];
      end else begin
        rd_valid <= 1'b0;
      end

      if (load) begin
        state    <= StFill;
        count    <= 4'd0;
        full     <= 1'b0;
        rcon_err <= 1'b0;
        busy     <= 1'b1;
      end else if (word_in) begin
        if (rcon_fail) begin
          rcon_err <= 1'b1;
          state    <= StIdle;
          busy     <= 1'b0;
          count    <= 4'd0;
        end else begin
          count <= count + 4'd1;
          if (count == LAST) begin
            state <= StReady;
            full  <= 1'b1;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

  // Slot contents survive reset; they are only reachable once full is set again.
  always_ff @(posedge clock) begin
    if (slot_we) slots[count] <= k_in;
  end

endmodule

// File: tb/tb_round_key_store.sv
// Randomized bench for round_key_store against a frame-level reference model.
module tb_round_key_store;

  logic         clock = 1'b0;
  logic         reset, load, empty_in, rd_req, rd_dir;
  logic [127:0] k_in;
  logic [7:0]   rcon_in;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
  logic         rd_valid, full, busy, rcon_err;
  logic [3:0]   count;

  always #5 clock = ~clock;

  round_key_store #(
    .KEY_W      (128),
    .ROUNDS     (10),
    .CHECK_RCON (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .k_in     (k_in),
    .rcon_in  (rcon_in),
    .empty_in (empty_in),
    .rd_req   (rd_req),
    .rd_dir   (rd_dir),
    .rd_round (rd_round),
    .rd_key   (rd_key),
    .rd_valid (rd_valid),
    .full     (full),
    .busy     (busy),
    .count    (count),
    .rcon_err (rcon_err)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [7:0] RCON_REF [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Reference model: phase 0 idle, 1 filling, 2 ready.
  logic [127:0] m_slot [11];
  int           m_phase = 0;
  int           m_count = 0;
  bit           m_full = 0, m_busy = 0, m_err = 0, m_rv = 0;
  logic [127:0] m_rk = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    int idx;
    if (reset) begin
      m_phase = 0; m_full = 0; m_busy = 0; m_count = 0; m_err = 0; m_rv = 0; m_rk = '0;
      return;
    end
    if (rd_req && m_full && !load) begin
      m_rv = 1;
      if (rd_round > 4'd10) m_rk = '0;
      else begin
        idx  = rd_dir ? 10 - int'(rd_round) : int'(rd_round);
        m_rk = m_slot[idx];
      end
    end else m_rv = 0;
    if (load) begin
      m_phase = 1; m_count = 0; m_full = 0; m_err = 0; m_busy = 1;
    end else if (m_phase == 1 && !empty_in) begin
      if (m_count >= 1 && rcon_in != RCON_REF[m_count-1]) begin
        m_err = 1; m_phase = 0; m_busy = 0; m_count = 0; m_full = 0;
      end else begin
        m_slot[m_count] = k_in;
        m_count++;
        if (m_count == 11) begin
          m_phase = 2; m_full = 1; m_busy = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
    check("full", 128'(full), 128'(m_full));
    check("busy", 128'(busy), 128'(m_busy));
    check("count", 128'(count), 128'(m_count));
    check("rcon_err", 128'(rcon_err), 128'(m_err));
    check("rd_valid", 128'(rd_valid), 128'(m_rv));
    check("rd_key", rd_key, m_rk);
  endtask

  task automatic idle_in();
    reset = 0; load = 0; empty_in = 1; rd_req = 0; rd_dir = 0; rd_round = 0;
    k_in = {$urandom, $urandom, $urandom, $urandom};
    rcon_in = 8'($urandom);
  endtask

  task automatic push(input logic [127:0] k, input logic [7:0] rc);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      idle_in();
      step();
    end
    idle_in();
    empty_in = 0; k_in = k; rcon_in = rc;
    step();
    idle_in();
  endtask

  task automatic do_load();
    idle_in();
    load = 1;
    step();
    idle_in();
  endtask

  task automatic read(input logic dir, input logic [3:0] r);
    idle_in();
    rd_req = 1; rd_dir = dir; rd_round = r;
    step();
    idle_in();
  endtask

  function automatic logic [7:0] good_rcon(input int slot);
    return (slot == 0) ? 8'($urandom) : RCON_REF[slot-1];
  endfunction

  initial begin
    idle_in();
    reset = 1;
    step();
    step();
    check("reset_full", 128'(full), 128'(0));
    check("reset_count", 128'(count), 128'(0));
    idle_in();

    // Nominal FIPS-197 frame with gaps
    do_load();
    for (int i = 0; i < 11; i++) begin
      check("full_early", 128'(full), 128'(0));
      push(FIPS[i], good_rcon(i));
    end
    check("nom_full", 128'(full), 128'(1));
    check("nom_count", 128'(count), 128'(11));
    check("nom_err", 128'(rcon_err), 128'(0));

    read(1'b0, 4'd1);
    check("fwd_r1", rd_key, FIPS[1]);
    read(1'b1, 4'd0);
    check("inv_r0", rd_key, FIPS[10]);
    read(1'b1, 4'd10);
    check("inv_r10", rd_key, FIPS[0]);
    read(1'b0, 4'd12);
    check("oob_valid", 128'(rd_valid), 128'(1));
    check("oob_key", rd_key, 128'(0));

    // Back-to-back reads
    for (int i = 0; i < 11; i++) begin
      idle_in();
      rd_req = 1; rd_dir = 1'($urandom); rd_round = 4'(i);
      step();
      check("b2b_valid", 128'(rd_valid), 128'(1));
    end
    idle_in();

    // Rcon corruption on slot 2
    do_load();
    push(FIPS[0], 8'h00);
    push(FIPS[1], 8'h01);
    push(FIPS[2], 8'h1b);
    check("corrupt_err", 128'(rcon_err), 128'(1));
    check("corrupt_full", 128'(full), 128'(0));
    check("corrupt_count", 128'(count), 128'(0));
    check("corrupt_busy", 128'(busy), 128'(0));
    do_load();
    check("load_clears_err", 128'(rcon_err), 128'(0));

    // Restart mid-frame with a same-cycle valid word
    for (int i = 0; i < 5; i++) push({$urandom, $urandom, $urandom, $urandom}, good_rcon(i));
    check("mid_count", 128'(count), 128'(5));
    idle_in();
    load = 1; empty_in = 0; rcon_in = good_rcon(5);
    step();
    check("restart_count", 128'(count), 128'(0));
    idle_in();
    read(1'b0, 4'd1);
    check("early_rd_valid", 128'(rd_valid), 128'(0));
    for (int i = 0; i < 10; i++) push({$urandom, $urandom, $urandom, $urandom}, good_rcon(i));
    check("restart_not_full", 128'(full), 128'(0));
    push({$urandom, $urandom, $urandom, $urandom}, good_rcon(10));
    check("restart_full", 128'(full), 128'(1));
    read(1'b0, 4'd5);

    // Reset at count 7
    do_load();
    for (int i = 0; i < 7; i++) push({$urandom, $urandom, $urandom, $urandom}, good_rcon(i));
    idle_in();
    reset = 1; empty_in = 0; rd_req = 1;
    step();
    check("rst_full", 128'(full), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_rd_key", rd_key, 128'(0));
    idle_in();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      reset    = ($urandom_range(0, 299) == 0);
      load     = ($urandom_range(0, 39) == 0);
      empty_in = ($urandom_range(0, 2) == 0);
      if (m_phase == 1 && $urandom_range(0, 59) != 0) rcon_in = good_rcon(m_count);
      rd_req   = 1'($urandom);
      rd_dir   = 1'($urandom);
      rd_round = 4'($urandom_range(0, 12));
      step();
    end
    idle_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
